idma_desc64_be_buffer: RTL and testbench

IDMA_DESC64_BE_BUFFER -- requirements
Module: idma_desc64_be_buffer

---
 rtl/idma_desc64_be_buffer_pkg.sv | 14 +
 rtl/idma_desc64_be_fifo.sv | 63 ++++++
 rtl/idma_desc64_be_buffer.sv | 110 +++++++++++
 tb/tb_idma_desc64_be_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/idma_desc64_be_buffer_pkg.sv
// Shared definitions for the descriptor-to-backend burst buffer.
//   DefaultDepth          : default number of buffered burst requests
//   DefaultMaxOutstanding : default cap on issued-but-uncompleted bursts
//   out_cnt_width()       : width needed to count 0..max_outstanding
package idma_desc64_be_buffer_pkg;

  localparam int unsigned DefaultDepth          = 32'd4;
  localparam int unsigned DefaultMaxOutstanding = 32'd8;

  function automatic int unsigned out_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 32'd1);
  endfunction

endpackage

// File: rtl/idma_desc64_be_fifo.sv
// Request FIFO with registered storage and no fall-through: an entry written
// on one edge is visible on data_o only after that edge.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   data_i, push_i    : write side; push is ignored while full
//   full_o            : no free entry
//   data_o, pop_i     : head entry and pop strobe; pop is ignored while empty
//   empty_o           : no valid entry
module idma_desc64_be_fifo
  import idma_desc64_be_buffer_pkg::*;
#(
  parameter int unsigned Depth  = DefaultDepth,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  data_t data_i,
  input  logic  push_i,
  output logic  full_o,
  output data_t data_o,
  input  logic  pop_i,
  output logic  empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PtrWidth:0] wr_ptr_r;
  logic [PtrWidth:0] rd_ptr_r;
  data_t             mem_r [Depth];
  logic              do_push_s;
  logic              do_pop_s;

  assign empty_o   = (wr_ptr_r == rd_ptr_r);
  assign full_o    = (wr_ptr_r[PtrWidth] != rd_ptr_r[PtrWidth]) &&
                     (wr_ptr_r[PtrWidth-1:0] == rd_ptr_r[PtrWidth-1:0]);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_r[rd_ptr_r[PtrWidth-1:0]];

  // Pointer registers; Depth is a power of two so plain overflow wraps correctly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {(PtrWidth+1){1'b0}};
      rd_ptr_r <= {(PtrWidth+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PtrWidth{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PtrWidth{1'b0}}, 1'b1};
      end
    end
  end

  // Payload storage; left unreset since the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PtrWidth-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/idma_desc64_be_buffer.sv
// Buffers burst requests between the descriptor frontend and the backend,
// limits the number of bursts in flight, forwards completions and reports idle.
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   req_i, req_valid_i, req_ready_o : frontend request handshake
//   be_req_o, be_valid_o, be_ready_i : backend request handshake
//   be_tx_complete_i, be_idle_i   : backend completion pulse and idle status
//   tx_complete_o                 : completion pulse, one cycle later
//   idle_o                        : registered whole-path idle
//   outstanding_o                 : bursts issued and not yet completed
//   err_o                         : sticky, completion seen with nothing outstanding
module idma_desc64_be_buffer
  import idma_desc64_be_buffer_pkg::*;
#(
  parameter int unsigned Depth          = DefaultDepth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter type         burst_req_t    = logic,
  localparam int unsigned OutCntWidth   = out_cnt_width(MaxOutstanding)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  burst_req_t             req_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output burst_req_t             be_req_o,
  output logic                   be_valid_o,
  input  logic                   be_ready_i,
  input  logic                   be_tx_complete_i,
  input  logic                   be_idle_i,
  output logic                   tx_complete_o,
  output logic                   idle_o,
  output logic [OutCntWidth-1:0] outstanding_o,
  output logic                   err_o
);

  localparam logic [OutCntWidth-1:0] CntZero = {OutCntWidth{1'b0}};
  localparam logic [OutCntWidth-1:0] CntOne  = OutCntWidth'(1'b1);
  localparam logic [OutCntWidth-1:0] CntMax  = OutCntWidth'(MaxOutstanding);

  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fifo_push_s;
  logic                   fifo_pop_s;
  logic [OutCntWidth-1:0] out_cnt_r;
  logic [OutCntWidth-1:0] out_cnt_next_s;
  logic                   err_set_s;
  logic                   err_r;
  logic                   tx_complete_r;
  logic                   idle_r;

  assign fifo_push_s = req_valid_i & ~fifo_full_s;
  // Issue only while a credit is left; the FIFO keeps filling regardless.
  assign be_valid_o  = ~fifo_empty_s & (out_cnt_r < CntMax);
  assign fifo_pop_s  = be_valid_o & be_ready_i;

  idma_desc64_be_fifo #(
    .Depth  (Depth),
    .data_t (burst_req_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (req_i),
    .push_i  (fifo_push_s),
    .full_o  (fifo_full_s),
    .data_o  (be_req_o),
    .pop_i   (fifo_pop_s),
    .empty_o (fifo_empty_s)
  );

  // Next outstanding count; an issue and a completion together cancel out,
  // which also keeps a completion at zero from flagging an error when it
  // coincides with an issue.
  always_comb begin
    out_cnt_next_s = out_cnt_r;
    err_set_s      = 1'b0;
    case ({fifo_pop_s, be_tx_complete_i})
      2'b10: out_cnt_next_s = out_cnt_r + CntOne;
      2'b01: begin
        if (out_cnt_r != CntZero) begin
          out_cnt_next_s = out_cnt_r - CntOne;
        end else begin
          err_set_s = 1'b1;
        end
      end
      default: out_cnt_next_s = out_cnt_r;
    endcase
  end

  // Counter, sticky error, completion delay and idle status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_r     <= CntZero;
      err_r         <= 1'b0;
      tx_complete_r <= 1'b0;
      idle_r        <= 1'b1;
    end else begin
      out_cnt_r     <= out_cnt_next_s;
      err_r         <= err_r | err_set_s;
      tx_complete_r <= be_tx_complete_i;
      idle_r        <= fifo_empty_s & (out_cnt_r == CntZero) & be_idle_i & ~req_valid_i;
    end
  end

  assign req_ready_o   = ~fifo_full_s;
  assign outstanding_o = out_cnt_r;
  assign err_o         = err_r;
  assign tx_complete_o = tx_complete_r;
  assign idle_o        = idle_r;

endmodule

// File: tb/tb_idma_desc64_be_buffer.sv
// Self-checking bench: two instances (MaxOutstanding 2 and 8, Depth 4) share
// the same stimulus. A counting reference model predicts the status outputs
// each cycle; accepted payloads go into per-instance scoreboards that a
// separate monitor drains on every backend handshake.
module tb_idma_desc64_be_buffer;

  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, req_valid_i, be_ready_i, be_tx_complete_i, be_idle_i;
  logic [15:0] req_i;

  logic        rdy0, val0, txc0, idl0, err0;
  logic [15:0] breq0;
  logic [1:0]  out0;
  logic        rdy1, val1, txc1, idl1, err1;
  logic [15:0] breq1;
  logic [3:0]  out1;

  idma_desc64_be_buffer #(
    .Depth(4), .MaxOutstanding(2), .burst_req_t(logic [15:0])
  ) dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_valid_i(req_valid_i),
    .req_ready_o(rdy0), .be_req_o(breq0), .be_valid_o(val0), .be_ready_i(be_ready_i),
    .be_tx_complete_i(be_tx_complete_i), .be_idle_i(be_idle_i),
    .tx_complete_o(txc0), .idle_o(idl0), .outstanding_o(out0), .err_o(err0)
  );

  idma_desc64_be_buffer #(
    .Depth(4), .MaxOutstanding(8), .burst_req_t(logic [15:0])
  ) dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_valid_i(req_valid_i),
    .req_ready_o(rdy1), .be_req_o(breq1), .be_valid_o(val1), .be_ready_i(be_ready_i),
    .be_tx_complete_i(be_tx_complete_i), .be_idle_i(be_idle_i),
    .tx_complete_o(txc1), .idle_o(idl1), .outstanding_o(out1), .err_o(err1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance.
  int m_max [2] = '{2, 8};
  int m_size[2];
  int m_out [2];
  bit m_err [2];
  bit m_idle[2];
  bit m_txc [2];
  bit known = 1'b0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic rdy, input logic val,
                            input logic [31:0] outs, input logic err,
                            input logic txc, input logic idl);
    chk($sformatf("req_ready%0d", k), {31'd0, rdy}, {31'd0, m_size[k] < Depth});
    chk($sformatf("be_valid%0d", k), {31'd0, val}, {31'd0, (m_size[k] > 0) && (m_out[k] < m_max[k])});
    chk($sformatf("outstanding%0d", k), outs, m_out[k]);
    chk($sformatf("err%0d", k), {31'd0, err}, {31'd0, m_err[k]});
    chk($sformatf("tx_complete%0d", k), {31'd0, txc}, {31'd0, m_txc[k]});
    chk($sformatf("idle%0d", k), {31'd0, idl}, {31'd0, m_idle[k]});
  endtask

  // One clock cycle: drive inputs, advance the model by the edge, check status.
  task automatic cyc(input bit rst, input bit v, input logic [15:0] d,
                     input bit rdy, input bit txc, input bit bidle);
    bit issue, accept, nidle;
    @(negedge clk);
    rst_i = rst; req_valid_i = v; req_i = d;
    be_ready_i = rdy; be_tx_complete_i = txc; be_idle_i = bidle;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_size[k] = 0; m_out[k] = 0; m_err[k] = 1'b0; m_idle[k] = 1'b1; m_txc[k] = 1'b0;
      end else begin
        issue  = (m_size[k] > 0) && (m_out[k] < m_max[k]) && rdy;
        accept = v && (m_size[k] < Depth);
        nidle  = (m_size[k] == 0) && (m_out[k] == 0) && bidle && !v;
        m_size[k] = m_size[k] + int'(accept) - int'(issue);
        if (accept) begin
          if (k == 0) exp0.push_back(d);
          else        exp1.push_back(d);
        end
        if (issue && !txc)      m_out[k]++;
        else if (txc && !issue) begin
          if (m_out[k] > 0) m_out[k]--;
          else              m_err[k] = 1'b1;
        end
        m_idle[k] = nidle;
        m_txc[k]  = txc;
      end
    end
    if (rst) begin
      exp0.delete();
      exp1.delete();
      known = 1'b1;
    end
    @(posedge clk);
    #1;
    if (known) begin
      check_inst(0, rdy0, val0, {30'd0, out0}, err0, txc0, idl0);
      check_inst(1, rdy1, val1, {28'd0, out1}, err1, txc1, idl1);
    end
  endtask

  // Monitor: on every backend handshake compare the head against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (known && !rst_i) begin
      if (val0 && be_ready_i) begin
        if (exp0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL be_req0: got %0h expected no request", breq0);
        end else begin
          chk("be_req0", {16'd0, breq0}, {16'd0, exp0.pop_front()});
        end
      end
      if (val1 && be_ready_i) begin
        if (exp1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL be_req1: got %0h expected no request", breq1);
        end else begin
          chk("be_req1", {16'd0, breq1}, {16'd0, exp1.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_i = 16'h0;
    be_ready_i = 1'b0; be_tx_complete_i = 1'b0; be_idle_i = 1'b1;

    // Reset state and in-order issue of A,B,C.
    cyc(1, 0, 16'h0, 0, 0, 1);
    chk("reset_ready", {31'd0, rdy1}, 32'd1);
    chk("reset_idle", {31'd0, idl1}, 32'd1);
    cyc(0, 1, 16'hA001, 1, 0, 1);
    chk("abc_first_valid", {31'd0, val1}, 32'd1);
    chk("abc_first_head", {16'd0, breq1}, 32'hA001);
    cyc(0, 1, 16'hB002, 1, 0, 1);
    cyc(0, 1, 16'hC003, 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    chk("abc_outstanding", {28'd0, out1}, 32'd3);

    // Fill to full with the backend stalled, then one pop reopens the input.
    cyc(1, 0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h1000 + 16'(i), 0, 0, 1);
    chk("full_ready_low", {31'd0, rdy1}, 32'd0);
    cyc(0, 1, 16'h1FFF, 0, 0, 1);
    chk("full_still_low", {31'd0, rdy1}, 32'd0);
    cyc(0, 0, 16'h0, 1, 0, 1);
    chk("pop_ready_high", {31'd0, rdy1}, 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 16'h0, 1, 1, 1);

    // Outstanding cap of 2 on dut0; one completion allows exactly one more issue.
    cyc(1, 0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h2000 + 16'(i), 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    chk("cap_valid_low", {31'd0, val0}, 32'd0);
    chk("cap_outstanding", {30'd0, out0}, 32'd2);
    cyc(0, 0, 16'h0, 1, 1, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    chk("cap_one_more_out", {30'd0, out0}, 32'd2);
    chk("cap_one_more_valid", {31'd0, val0}, 32'd0);

    // Completion together with an issue at count 1.
    cyc(1, 0, 16'h0, 0, 0, 1);
    cyc(0, 1, 16'h3001, 0, 0, 1);
    cyc(0, 1, 16'h3002, 0, 0, 1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    cyc(0, 0, 16'h0, 1, 1, 1);
    chk("inc_dec_count", {28'd0, out1}, 32'd1);
    chk("inc_dec_txc", {31'd0, txc1}, 32'd1);
    cyc(0, 0, 16'h0, 0, 0, 1);
    chk("txc_one_cycle", {31'd0, txc1}, 32'd0);

    // Completion with nothing outstanding latches the error until reset.
    cyc(1, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 1, 1);
    chk("err_set", {31'd0, err1}, 32'd1);
    chk("err_count_zero", {28'd0, out1}, 32'd0);
    cyc(0, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 0, 1);
    chk("err_sticky", {31'd0, err1}, 32'd1);
    cyc(1, 0, 16'h0, 0, 0, 1);
    chk("err_cleared", {31'd0, err1}, 32'd0);

    // Reset with 2 queued and 3 outstanding.
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h4000 + 16'(i), 1, 0, 1);
    cyc(0, 1, 16'h4004, 0, 0, 1);
    chk("pre_reset_out", {28'd0, out1}, 32'd3);
    cyc(1, 0, 16'h0, 0, 0, 1);
    chk("mid_reset_valid", {31'd0, val1}, 32'd0);
    chk("mid_reset_out", {28'd0, out1}, 32'd0);
    chk("mid_reset_idle", {31'd0, idl1}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60,
          16'($urandom),
          $urandom_range(0, 99) < 55,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
